// File: rtl/adder_scheduler.sv
// Two-requester round-robin scheduler sharing one 4-bit slice adder, one nibble per cycle.
// Latency NIBBLES+1 cycles gnt->done; no new grant while busy, requests simply wait.
module adder_scheduler #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [1:0]           req,
    input  logic [4*NIBBLES-1:0] a0,
    input  logic [4*NIBBLES-1:0] b0,
    input  logic                 ci0,
    input  logic [4*NIBBLES-1:0] a1,
    input  logic [4*NIBBLES-1:0] b1,
    input  logic                 ci1,
    output logic [1:0]           gnt,
    output logic                 busy,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 co,
    output logic                 done,
    output logic                 done_id
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] k;
    logic          carry;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  res;
    logic [W-1:0]  res_upd;
    logic          cur_id;
    logic          last_id;
    logic          pick;
    logic          last_nib;
    logic [4:0]    slice;

    // Contention goes to whoever was not served last; a lone request wins outright.
    always_comb begin
        pick = (req == 2'b11) ? ~last_id : req[1];
    end

    always_comb begin
        slice    = {1'b0, op_a[{k, 2'b00} +: 4]} + {1'b0, op_b[{k, 2'b00} +: 4]} + {4'b0, carry};
        res_upd  = res;
        res_upd[{k, 2'b00} +: 4] = slice[3:0];
        last_nib = (k == KW'(NIBBLES - 1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt       = 2'b00;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt       = pick ? 2'b10 : 2'b01;
                    busy      = 1'b1;
                    state_nxt = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (last_nib) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Requests seen while reset is asserted must not produce a visible grant.
        if (!resetn) begin
            gnt       = 2'b00;
            busy      = 1'b0;
            done      = 1'b0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            k       <= '0;
            carry   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            res     <= '0;
            sum     <= '0;
            co      <= 1'b0;
            done_id <= 1'b0;
            cur_id  <= 1'b0;
            last_id <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        cur_id  <= pick;
                        last_id <= pick;
                        op_a    <= pick ? a1 : a0;
                        op_b    <= pick ? b1 : b0;
                        carry   <= pick ? ci1 : ci0;
                        k       <= '0;
                    end
                end
                ADD: begin
                    res   <= res_upd;
                    carry <= slice[4];
                    // Publish on the edge into DONE so sum/co/done_id are valid alongside done.
                    if (last_nib) begin
                        k       <= '0;
                        sum     <= res_upd;
                        co      <= slice[4];
                        done_id <= cur_id;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
